dmem_resp: RTL and testbench

- Data-memory responder on the far side of the MEM stage's load path; owns the data RAM.
- Accepts load/store requests over a valid/ready handshake and performs byte/half/word accesses on a byte-writable synchronous array.
- Returns load data already aligned and sign/zero-extended, so the MEM stage passes it straight to rd_data.
- Handles backpressure, programmable wait states and access errors.

---
 rtl/dmem_resp_pkg.sv | 51 +++++
 rtl/dmem_sram.sv | 25 ++
 rtl/dmem_resp.sv | 138 +++++++++++++
 tb/tb_dmem_resp.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared size/state encodings and byte-lane helpers for the data-memory responder.
package dmem_resp_pkg;

  localparam logic [1:0]  MEM_SIZE_B       = 2'b00;
  localparam logic [1:0]  MEM_SIZE_H       = 2'b01;
  localparam logic [1:0]  MEM_SIZE_W       = 2'b10;
  localparam logic [1:0]  MEM_SIZE_ILLEGAL = 2'b11;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_ACCESS,
    DMEM_RESP
  } dmem_state_e;

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      MEM_SIZE_B: be = 4'b0001 << lane;
      MEM_SIZE_H: be = 4'b0011 << lane;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate_store(input logic [31:0] data, input logic [1:0] size);
    logic [31:0] lanes;
    case (size)
      MEM_SIZE_B: lanes = {4{data[7:0]}};
      MEM_SIZE_H: lanes = {2{data[15:0]}};
      default:    lanes = data;
    endcase
    return lanes;
  endfunction

  // Bring the addressed lane down to bit 0, then extend to a full register.
  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = word >> {lane, 3'b000};
    case (size)
      MEM_SIZE_B: result = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      MEM_SIZE_H: result = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default:    result = shifted;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Byte-writable synchronous data array; read data is registered on an enabled cycle with no byte enables.
module dmem_sram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (be == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: valid/ready request in, aligned/extended response out, with wait states.
// Optional DMEM_MISALIGN_ERR_EN: misaligned half/word accesses raise an error instead of being aligned down.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam dmem_state_e AFTER_ACCEPT = (WAIT_CYCLES != 0) ? DMEM_WAIT : DMEM_ACCESS;

  dmem_state_e   state, state_next;
  logic [3:0]    wait_cnt;
  logic          accept;
  logic [31:0]   offset;
  logic          out_of_range;
  logic          err_d;
  logic [1:0]    lane_d;

  logic          we_q, uns_q, err_q;
  logic [1:0]    size_q, lane_q;
  logic [31:0]   wdata_q;
  logic [AW-1:0] index_q;

  logic          sram_en;
  logic [3:0]    sram_be;
  logic [31:0]   sram_rdata;

  assign offset       = req_addr_i - BASE_ADDR;
  assign out_of_range = (req_addr_i < BASE_ADDR) || ({1'b0, offset} >= SPAN);
  assign accept       = req_valid_i && req_ready_o;

`ifdef DMEM_MISALIGN_ERR_EN
  logic misaligned;
  assign misaligned = ((req_size_i == MEM_SIZE_H) && req_addr_i[0]) ||
                      ((req_size_i == MEM_SIZE_W) && (req_addr_i[1:0] != 2'b00));
  assign err_d  = out_of_range || (req_size_i == MEM_SIZE_ILLEGAL) || misaligned;
  assign lane_d = req_addr_i[1:0];
`else
  assign err_d = out_of_range || (req_size_i == MEM_SIZE_ILLEGAL);
  always_comb begin
    lane_d = req_addr_i[1:0];
    if (req_size_i == MEM_SIZE_H) lane_d[0] = 1'b0;
    else if (req_size_i == MEM_SIZE_W) lane_d = 2'b00;
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= DMEM_IDLE;
    else       state <= state_next;
  end

  // Consuming a response in RESP reopens the request port in the same cycle.
  always_comb begin
    state_next  = state;
    req_ready_o = 1'b0;
    case (state)
      DMEM_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_next = AFTER_ACCEPT;
      end
      DMEM_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_next = DMEM_ACCESS;
      end
      DMEM_ACCESS: state_next = DMEM_RESP;
      DMEM_RESP: begin
        if (rsp_ready_i) begin
          req_ready_o = 1'b1;
          state_next  = req_valid_i ? AFTER_ACCEPT : DMEM_IDLE;
        end
      end
      default: state_next = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= MEM_SIZE_B;
      lane_q   <= 2'b00;
      wdata_q  <= ZERO_WORD;
      index_q  <= '0;
    end else if (accept) begin
      wait_cnt <= 4'd0;
      we_q     <= req_we_i;
      uns_q    <= req_unsigned_i;
      err_q    <= err_d;
      size_q   <= req_size_i;
      lane_q   <= lane_d;
      wdata_q  <= req_wdata_i;
      index_q  <= offset[AW+1:2];
    end else if (state == DMEM_WAIT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign sram_en = (state == DMEM_ACCESS) && !err_q;
  assign sram_be = we_q ? byte_enables(size_q, lane_q) : 4'b0000;

  dmem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .be   (sram_be),
    .addr (index_q),
    .wdata(replicate_store(wdata_q, size_q)),
    .rdata(sram_rdata)
  );

  assign rsp_valid_o = (state == DMEM_RESP);
  assign rsp_err_o   = (state == DMEM_RESP) && err_q;
  assign rsp_rdata_o = ((state == DMEM_RESP) && !we_q && !err_q) ?
                       extract_load(sram_rdata, lane_q, size_q, uns_q) : ZERO_WORD;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: two instances (no wait states / three wait states with offset base) against a byte-addressed model.
module tb_dmem_resp;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;
  localparam int DEPTH0 = 4096;
  localparam int DEPTH1 = 64;
  localparam int WAIT0  = 0;
  localparam int WAIT1  = 3;

  logic        clk = 1'b0;
  logic [1:0]  rstn, req_valid, req_we, req_unsigned, rsp_ready;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  req_size [2];
  wire  [1:0]  req_ready, rsp_valid, rsp_err;
  wire  [31:0] rsp_rdata0, rsp_rdata1;

  int check_count = 0;
  int pass_count  = 0;

  logic [7:0] mref [longint];

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH_WORDS(DEPTH0), .WAIT_CYCLES(WAIT0), .BASE_ADDR(BASE0)) dut0 (
    .clk(clk), .rstn(rstn[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_we_i(req_we[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .req_size_i(req_size[0]), .req_unsigned_i(req_unsigned[0]), .rsp_valid_o(rsp_valid[0]),
    .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err[0])
  );

  dmem_resp #(.DEPTH_WORDS(DEPTH1), .WAIT_CYCLES(WAIT1), .BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .rstn(rstn[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_we_i(req_we[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .req_size_i(req_size[1]), .req_unsigned_i(req_unsigned[1]), .rsp_valid_o(rsp_valid[1]),
    .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata1), .rsp_err_o(rsp_err[1])
  );

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? DEPTH0 : DEPTH1;
  endfunction

  function automatic int wait_of(input int d);
    return (d == 0) ? WAIT0 : WAIT1;
  endfunction

  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? rsp_rdata0 : rsp_rdata1;
  endfunction

  function automatic longint mkey(input int d, input logic [31:0] a);
    return (longint'(d) << 32) | longint'(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // Byte-addressed memory model: a store writes 2^size bytes, a load gathers them little-endian.
  task automatic refModel(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns,
                          output logic [31:0] exp_rdata, output logic exp_err);
    longint lo, hi, a64;
    logic [31:0] a, v;
    int n;
    exp_rdata = 32'h0;
    exp_err   = 1'b0;
    lo  = longint'(base_of(d));
    hi  = lo + 4 * depth_of(d);
    a64 = longint'(addr);
    if (a64 < lo || a64 >= hi) exp_err = 1'b1;
    if (size == 2'b11) exp_err = 1'b1;
    a = addr;
`ifdef DMEM_MISALIGN_ERR_EN
    if ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)) exp_err = 1'b1;
`else
    if (size == 2'b01) a[0] = 1'b0;
    if (size == 2'b10) a[1:0] = 2'b00;
`endif
    if (exp_err) return;
    n = 1 << size;
    if (we) begin
      for (int i = 0; i < n; i++) mref[mkey(d, a + i)] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mref[mkey(d, a + i)]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      exp_rdata = v;
    end
  endtask

  task automatic waitRsp(input int d, output int lat);
    lat = 1;
    while (!rsp_valid[d] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Entered and left at #1 after a rising edge; latency counts edges from the accepting one.
  task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic uns,
                               output logic [31:0] rdata, output logic err);
    logic [31:0] exp_rdata;
    logic exp_err;
    int lat, n;
    refModel(d, we, addr, wdata, size, uns, exp_rdata, exp_err);
    req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
    req_size[d] = size; req_unsigned[d] = uns;
    req_valid[d] = 1'b1; rsp_ready[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput($sformatf("ready d%0d", d), 32'(req_ready[d]), 32'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    waitRsp(d, lat);
    rdata = get_rdata(d);
    err   = rsp_err[d];
    checkOutput($sformatf("latency d%0d @%h", d, addr), 32'(lat), 32'(2 + wait_of(d)));
    checkOutput($sformatf("rdata d%0d @%h sz%0d", d, addr, size), rdata, exp_rdata);
    checkOutput($sformatf("err d%0d @%h sz%0d", d, addr, size), 32'(err), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd, addr;
    logic er, we, uns;
    logic [1:0] size;
    int lat, d, r;

    rstn = 2'b00; req_valid = 2'b00; req_we = 2'b00; req_unsigned = 2'b00; rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = 32'h0; req_wdata[i] = 32'h0; req_size[i] = 2'b00;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("rst ready d%0d", i), 32'(req_ready[i]), 32'd1);
      checkOutput($sformatf("rst valid d%0d", i), 32'(rsp_valid[i]), 32'd0);
      checkOutput($sformatf("rst err d%0d", i), 32'(rsp_err[i]), 32'd0);
      checkOutput($sformatf("rst rdata d%0d", i), get_rdata(i), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1 rstn = 2'b11;
    @(posedge clk); #1;

    $display("[TB] preloading a 64-byte window in both instances");
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 16; w++)
        applyStimulus(i, 1'b1, base_of(i) + 32'(4 * w), $urandom, 2'b10, 1'b0, rd, er);

    $display("[TB] directed loads/stores on the zero-wait instance");
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, er);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er);
    checkOutput("lw deadbeef", rd, 32'hDEADBEEF);
    applyStimulus(0, 1'b1, 32'h13, 32'h0000_0080, 2'b00, 1'b0, rd, er);
    applyStimulus(0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, rd, er);
    checkOutput("lb 0x13", rd, 32'hFFFF_FF80);
    applyStimulus(0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, rd, er);
    checkOutput("lbu 0x13", rd, 32'h0000_0080);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er);
    checkOutput("lw after sb", rd, 32'h80AD_BEEF);
    applyStimulus(0, 1'b0, 32'h4000, 32'h0, 2'b10, 1'b0, rd, er);
    checkOutput("oor lw err", 32'(er), 32'd1);
    checkOutput("oor lw rdata", rd, 32'd0);
    applyStimulus(0, 1'b1, 32'h4000, 32'h1234_5678, 2'b01, 1'b0, rd, er);
    checkOutput("oor sh err", 32'(er), 32'd1);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd, er);
    applyStimulus(0, 1'b0, 32'h11, 32'h0, 2'b01, 1'b0, rd, er);
`ifdef DMEM_MISALIGN_ERR_EN
    checkOutput("lh 0x11 err", 32'(er), 32'd1);
`else
    checkOutput("lh 0x11 aligned", rd, 32'hFFFF_BEEF);
`endif

    $display("[TB] backpressure and same-cycle reissue");
    req_we[0] = 1'b0; req_addr[0] = 32'h10; req_size[0] = 2'b10; req_unsigned[0] = 1'b0;
    req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    waitRsp(0, lat);
    checkOutput("bp latency", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp valid", 32'(rsp_valid[0]), 32'd1);
      checkOutput("bp rdata", rsp_rdata0, 32'h80AD_BEEF);
      checkOutput("bp ready", 32'(req_ready[0]), 32'd0);
      @(posedge clk); #1;
    end
    req_addr[0] = 32'h13; req_size[0] = 2'b00; req_unsigned[0] = 1'b1;
    req_valid[0] = 1'b1; rsp_ready[0] = 1'b1;
    #1;
    checkOutput("reissue ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    checkOutput("reissue valid low", 32'(rsp_valid[0]), 32'd0);
    waitRsp(0, lat);
    checkOutput("reissue latency", 32'(lat), 32'd2);
    checkOutput("reissue rdata", rsp_rdata0, 32'h0000_0080);
    @(posedge clk); #1;

    $display("[TB] reset during wait states");
    addr = BASE1 + 32'h8;
    req_we[1] = 1'b1; req_addr[1] = addr; req_wdata[1] = 32'h1234_5678;
    req_size[1] = 2'b10; req_valid[1] = 1'b1; rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rstn[1] = 1'b0;
    #1;
    checkOutput("midrst valid", 32'(rsp_valid[1]), 32'd0);
    checkOutput("midrst ready", 32'(req_ready[1]), 32'd1);
    checkOutput("midrst rdata", rsp_rdata1, 32'd0);
    @(posedge clk); #1;
    rstn[1] = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, addr, 32'h0, 2'b10, 1'b0, rd, er);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      d    = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r    = int'($urandom_range(0, 19));
      if (r == 0)
        addr = base_of(d) + 32'(4 * depth_of(d)) + $urandom_range(0, 15);
      else if (r == 1 && d == 1)
        addr = base_of(d) - $urandom_range(1, 16);
      else
        addr = base_of(d) + $urandom_range(0, 63);
      applyStimulus(d, we, addr, $urandom, size, uns, rd, er);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
